// File: rtl/alu_muldiv_seq_pkg.sv
// Shared constants for the multiply/divide sequencer: data width, ALU opcodes
// and op_sel encodings.
package alu_muldiv_seq_pkg;
  localparam int DATA_LEN   = 32;
  localparam int ALU_OPCODE = 4;

  localparam logic [ALU_OPCODE-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OPCODE-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_OPCODE-1:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;
endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply / divide / remainder built on top of the
// existing single-cycle ALU (ADD, SUB, SLT only).
//
// state      | meaning
// S_IDLE     | waiting for start, ALU inputs parked at 0/0/ADD
// S_MUL_STEP | one shift-and-add multiply iteration per cycle
// S_DIV_CMP  | restoring divide: shift in next dividend bit, compare against D
// S_DIV_SUB  | restoring divide: conditionally subtract D from the remainder
// S_DONE     | one-cycle done pulse; may accept the next start
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int DATA_W = DATA_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op_sel,
  input  logic [DATA_W-1:0]     opa,
  input  logic [DATA_W-1:0]     opb,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     result,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [ALU_OPCODE-1:0] alu_op,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zero
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_STEP,
    S_DIV_CMP,
    S_DIV_SUB,
    S_DONE
  } state_t;

  state_t state, state_n;

  // acc holds the product accumulator or the remainder R; mc holds the shifting
  // multiplicand or the divisor D; q holds the multiplier or the quotient/dividend.
  logic [DATA_W-1:0] acc, mc, q;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        op_r;
  logic              ge_q;
  logic              accept;
  logic [DATA_W-1:0] rs;
  logic              ge;

  always_comb begin
    state_n = state;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = ALU_ADD;
    accept  = start && (state == S_IDLE || state == S_DONE);
    rs      = {acc[DATA_W-2:0], q[DATA_W-1]};
    // SLT yields 0 when rs >= D; a bit shifted out of R means rs exceeds D anyway
    ge      = acc[DATA_W-1] | alu_zero;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          case (op_sel)
            OP_MULU:          state_n = S_MUL_STEP;
            OP_DIVU, OP_REMU: state_n = (opb == '0) ? S_DONE : S_DIV_CMP;
            default:          state_n = S_DONE;
          endcase
        end else begin
          state_n = S_IDLE;
        end
      end
      S_MUL_STEP: begin
        alu_a = acc;
        alu_b = mc;
        if (cnt == CNT_LAST) state_n = S_DONE;
      end
      S_DIV_CMP: begin
        alu_a   = rs;
        alu_b   = mc;
        alu_op  = ALU_SLT;
        state_n = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        alu_a   = acc;
        alu_b   = mc;
        alu_op  = ALU_SUB;
        state_n = (cnt == CNT_LAST) ? S_DONE : S_DIV_CMP;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      mc     <= '0;
      q      <= '0;
      cnt    <= '0;
      op_r   <= '0;
      ge_q   <= 1'b0;
      result <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            acc  <= '0;
            cnt  <= '0;
            op_r <= op_sel;
            mc   <= (op_sel == OP_MULU) ? opa : opb;
            q    <= (op_sel == OP_MULU) ? opb : opa;
            if (op_sel == OP_RSVD)
              result <= '0;
            else if (op_sel != OP_MULU && opb == '0)
              result <= (op_sel == OP_DIVU) ? '1 : opa;
          end
        end
        S_MUL_STEP: begin
          if (q[0]) acc <= alu_result;
          mc  <= mc << 1;
          q   <= q >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) result <= q[0] ? alu_result : acc;
        end
        S_DIV_CMP: begin
          acc  <= rs;
          q    <= {q[DATA_W-2:0], ge};
          ge_q <= ge;
        end
        S_DIV_SUB: begin
          if (ge_q) acc <= alu_result;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST)
            result <= (op_r == OP_REMU) ? (ge_q ? alu_result : acc) : q;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_MUL_STEP) || (state == S_DIV_CMP) || (state == S_DIV_SUB);
  assign done = (state == S_DONE);
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq paired with a small behavioural model of
// the single-cycle ALU (ADD/SUB/unsigned SLT).
module tb_alu_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op_sel;
  logic [31:0] opa, opb;
  logic        busy, done;
  logic [31:0] result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = {31'd0, (alu_a < alu_b)};
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Issue one operation and follow it to its done cycle; returns latency in
  // cycles after the accepting edge and the number of cycles with bad busy/opcode.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic is_div, output int lat, output logic [31:0] res,
                        output int bad_cycles);
    logic [3:0] exp_op;
    start = 1'b1; op_sel = op; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; opa = '0; opb = '0;
    lat = 1; bad_cycles = 0;
    while (!done && lat < 200) begin
      exp_op = is_div ? (lat[0] ? 4'b0111 : 4'b0110) : 4'b0010;
      if (busy !== 1'b1 || alu_op !== exp_op) bad_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b0) bad_cycles++;
    res = result;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (alu_op !== 4'b0010 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      errors++; $display("FAIL reset_alu got op=%b a=%h b=%h want 0010/0/0", alu_op, alu_a, alu_b);
    end
  endtask

  task automatic test_mulu();
    int lat, bad; logic [31:0] res;
    idle_cycle();
    run_op(2'b00, 32'd7, 32'd6, 1'b0, lat, res, bad);
    checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency got %0d want 33", lat); end
    checks++; if (res !== 32'd42) begin errors++; $display("FAIL mul_7x6 got %h want 0000002a", res); end
    checks++; if (bad != 0) begin errors++; $display("FAIL mul_busy_op got %0d bad cycles want 0", bad); end
    idle_cycle();
    checks++; if (done !== 1'b0 || result !== 32'd42) begin
      errors++; $display("FAIL mul_done_pulse got done=%0b result=%h want 0/0000002a", done, result);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bad; logic [31:0] res;
    idle_cycle();
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, res, bad);
    checks++; if (res !== 32'h00000001) begin errors++; $display("FAIL mul_ones got %h want 00000001", res); end
    run_op(2'b00, 32'h00010000, 32'h00010000, 1'b0, lat, res, bad);
    checks++; if (res !== 32'h00000000 || lat != 33) begin
      errors++; $display("FAIL mul_b2b got %h lat %0d want 00000000 lat 33", res, lat);
    end
    run_op(2'b00, 32'h12345678, 32'h00000010, 1'b0, lat, res, bad);
    checks++; if (res !== 32'h23456780 || bad != 0) begin
      errors++; $display("FAIL mul_shift got %h bad %0d want 23456780 bad 0", res, bad);
    end
  endtask

  task automatic test_divrem();
    int lat, bad; logic [31:0] res;
    idle_cycle();
    run_op(2'b01, 32'd100, 32'd7, 1'b1, lat, res, bad);
    checks++; if (lat != 65) begin errors++; $display("FAIL div_latency got %0d want 65", lat); end
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h want 0000000e", res); end
    checks++; if (bad != 0) begin errors++; $display("FAIL div_busy_op got %0d bad cycles want 0", bad); end
    run_op(2'b10, 32'd100, 32'd7, 1'b1, lat, res, bad);
    checks++; if (res !== 32'd2 || bad != 0) begin
      errors++; $display("FAIL remu_100_7 got %h bad %0d want 00000002 bad 0", res, bad);
    end
  endtask

  task automatic test_carry();
    int lat, bad; logic [31:0] res;
    idle_cycle();
    run_op(2'b10, 32'hFFFFFFFF, 32'h80000001, 1'b1, lat, res, bad);
    checks++; if (res !== 32'h7FFFFFFE) begin errors++; $display("FAIL remu_carry got %h want 7ffffffe", res); end
    run_op(2'b01, 32'hFFFFFFFF, 32'h80000001, 1'b1, lat, res, bad);
    checks++; if (res !== 32'h00000001) begin errors++; $display("FAIL divu_carry got %h want 00000001", res); end
    run_op(2'b01, 32'hFFFFFFFF, 32'h00000003, 1'b1, lat, res, bad);
    checks++; if (res !== 32'h55555555) begin errors++; $display("FAIL divu_max_3 got %h want 55555555", res); end
  endtask

  task automatic test_divzero();
    int lat, bad; logic [31:0] res;
    idle_cycle();
    run_op(2'b01, 32'd55, 32'd0, 1'b1, lat, res, bad);
    checks++; if (res !== 32'hFFFFFFFF || lat != 1) begin
      errors++; $display("FAIL divu_by0 got %h lat %0d want ffffffff lat 1", res, lat);
    end
    run_op(2'b10, 32'd55, 32'd0, 1'b1, lat, res, bad);
    checks++; if (res !== 32'd55 || lat != 1) begin
      errors++; $display("FAIL remu_by0 got %h lat %0d want 00000037 lat 1", res, lat);
    end
    run_op(2'b11, 32'd9, 32'd4, 1'b0, lat, res, bad);
    checks++; if (res !== 32'd0 || lat != 1) begin
      errors++; $display("FAIL reserved_op got %h lat %0d want 00000000 lat 1", res, lat);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    idle_cycle();
    start = 1'b1; op_sel = 2'b00; opa = 32'd7; opb = 32'd6;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    while (!done && lat < 200) begin
      start = (lat == 10);
      if (lat == 10) begin op_sel = 2'b01; opa = 32'd3; opb = 32'd3; end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checks++; if (result !== 32'd42 || lat != 33) begin
      errors++; $display("FAIL ignore_start got %h lat %0d want 0000002a lat 33", result, lat);
    end
  endtask

  task automatic test_reset_abort();
    int done_seen;
    idle_cycle();
    start = 1'b1; op_sel = 2'b01; opa = 32'd100; opb = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) idle_cycle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_prebusy got %0b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++; $display("FAIL abort_reset got busy=%0b done=%0b result=%h want 0/0/0", busy, done, result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    repeat (80) begin
      idle_cycle();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", done_seen); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_sel = 2'b00; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_mulu();
    test_back_to_back();
    test_divrem();
    test_carry();
    test_divzero();
    test_ignore_start();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
